// File: rtl/stage_reorder_if.sv
// Pair-stream bundle around the inter-stage permutation buffer.
// Input pairs flow from the master into the block, and re-paired words flow back out.
interface stage_reorder_if #(
  parameter int W = 28
);
  logic         in_valid;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         out_valid;
  logic         out_first;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;

  modport master (
    output in_valid, x_in, y_in,
    input  out_valid, out_first, x_out, y_out
  );

  modport slave (
    input  in_valid, x_in, y_in,
    output out_valid, out_first, x_out, y_out
  );
endinterface

// File: rtl/stage_reorder.sv
// Ping-pong permutation buffer between butterfly stages: pair k arrives as (F[k], F[k+PAIRS])
// and pair j leaves as (F[2j], F[2j+1]), one burst per completed frame.
module stage_reorder #(
  parameter int W     = 28,
  parameter int PAIRS = 4
) (
  input  logic           clk,
  input  logic           rst,
  stage_reorder_if.slave bus
);
  localparam int              KW   = $clog2(PAIRS);
  localparam int              WORDS = 2 * PAIRS;
  localparam logic [KW-1:0]   LAST = KW'(PAIRS - 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [W-1:0]  bank [2][WORDS];

  logic [KW-1:0] wr_cnt;
  logic          wb;
  logic          wr_last;
  logic          rd_start_p0;
  logic          done_bank_p0;

  state_t        state, state_next;
  logic [KW-1:0] rd_cnt, rd_cnt_next;
  logic          rb, rb_next;

  assign wr_last = bus.in_valid && (wr_cnt == LAST);

  // Write side: count pairs, flip banks at frame end, raise read start one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt       <= '0;
      wb           <= 1'b0;
      rd_start_p0  <= 1'b0;
      done_bank_p0 <= 1'b0;
    end else begin
      rd_start_p0 <= wr_last;
      if (bus.in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) begin
          wb           <= ~wb;
          done_bank_p0 <= wb;
        end
      end
    end
  end

  // PAIRS is a power of two, so the upper/lower halves are selected by the index MSB
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      bank[wb][{1'b0, wr_cnt}] <= bus.x_in;
      bank[wb][{1'b1, wr_cnt}] <= bus.y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_cnt <= '0;
      rb     <= 1'b0;
    end else begin
      state  <= state_next;
      rd_cnt <= rd_cnt_next;
      rb     <= rb_next;
    end
  end

  // A new read start can only coincide with the final pair of a burst
  always_comb begin
    state_next  = state;
    rd_cnt_next = rd_cnt;
    rb_next     = rb;
    case (state)
      IDLE: begin
        if (rd_start_p0) begin
          state_next  = BURST;
          rd_cnt_next = '0;
          rb_next     = done_bank_p0;
        end
      end
      BURST: begin
        rd_cnt_next = rd_cnt + 1'b1;
        if (rd_cnt == LAST) begin
          if (rd_start_p0) begin
            rb_next = done_bank_p0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output stage: registered pair, data holds between bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
    end else begin
      bus.out_valid <= (state == BURST);
      bus.out_first <= (state == BURST) && (rd_cnt == '0);
      if (state == BURST) begin
        bus.x_out <= bank[rb][{rd_cnt, 1'b0}];
        bus.y_out <= bank[rb][{rd_cnt, 1'b1}];
      end
    end
  end
endmodule

// File: tb/tb_stage_reorder.sv
// Scoreboard bench for stage_reorder: expected pairs and their output edge are queued as
// each frame completes, and popped as the block emits them.
module tb_stage_reorder;
  localparam int W     = 28;
  localparam int PAIRS = 4;
  localparam int WORDS = 2 * PAIRS;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         first;
    int           at_edge;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_q = 1'b1;
  int   cyc_n = 0;
  int   total = 0;
  int   bad   = 0;

  exp_t         sb [$];
  logic [W-1:0] hold_x = '0;
  logic [W-1:0] hold_y = '0;
  logic [W-1:0] fbuf [WORDS];
  int           wk = 0;

  logic [W-1:0] f    [WORDS];
  int           gaps [PAIRS];

  stage_reorder_if #(.W(W)) bus ();

  stage_reorder #(.W(W), .PAIRS(PAIRS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_q <= rst;
    cyc_n <= cyc_n + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, want, cyc_n);
    end
  endtask

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      check_val("rst_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_first", 64'(bus.out_first), 64'd0);
      check_val("rst_x", 64'(bus.x_out), 64'd0);
      check_val("rst_y", 64'(bus.y_out), 64'd0);
      hold_x = '0;
      hold_y = '0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("x_out", 64'(bus.x_out), 64'(e.x));
        check_val("y_out", 64'(bus.y_out), 64'(e.y));
        check_val("out_first", 64'(bus.out_first), 64'(e.first));
        check_val("out_edge", 64'(cyc_n), 64'(e.at_edge));
      end
      hold_x = bus.x_out;
      hold_y = bus.y_out;
    end else begin
      check_val("idle_first", 64'(bus.out_first), 64'd0);
      check_val("hold_x", 64'(bus.x_out), 64'(hold_x));
      check_val("hold_y", 64'(bus.y_out), 64'(hold_y));
    end
    if (rst) sb.delete();
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pair(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    fbuf[wk]         = x;
    fbuf[wk + PAIRS] = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (wk == PAIRS - 1) begin
      for (int j = 0; j < PAIRS; j++) begin
        e.x       = fbuf[2 * j];
        e.y       = fbuf[2 * j + 1];
        e.first   = (j == 0);
        e.at_edge = cyc_n + 2 + j;
        sb.push_back(e);
      end
    end
    wk = (wk + 1) % PAIRS;
  endtask

  task automatic send_frame(input logic [W-1:0] fr [WORDS], input int gp [PAIRS]);
    for (int p = 0; p < PAIRS; p++) begin
      idle(gp[p]);
      send_pair(fr[p], fr[p + PAIRS]);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wk  = 0;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    for (int p = 0; p < PAIRS; p++) gaps[p] = 0;

    do_reset(3);
    idle(2);

    // Single frame, continuous
    for (int i = 0; i < WORDS; i++) f[i] = W'(i);
    send_frame(f, gaps);
    idle(8);

    // Three back-to-back frames
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < WORDS; i++) f[i] = W'(8 * n + i);
      send_frame(f, gaps);
    end
    idle(8);

    // Gapped input: valid pattern 1,0,0,1,1,0,1
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 1;
    for (int i = 0; i < WORDS; i++) f[i] = W'(i);
    send_frame(f, gaps);
    for (int p = 0; p < PAIRS; p++) gaps[p] = 0;
    idle(8);

    // Reset after two pairs of a partial frame
    send_pair(W'(100), W'(104));
    send_pair(W'(101), W'(105));
    do_reset(2);
    send_frame(f, gaps);
    idle(8);

    // Reset in the middle of a burst, right after pair (2,3)
    send_frame(f, gaps);
    idle(3);
    do_reset(2);
    idle(8);

    // Full-width words
    f[0] = 28'h0000000; f[1] = 28'hFFFFFFF; f[2] = 28'hFFF0000; f[3] = 28'h0000001;
    f[4] = 28'hABCDEF1; f[5] = 28'h8000000; f[6] = 28'h5555555; f[7] = 28'hAAAAAAA;
    send_frame(f, gaps);
    idle(8);

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
